// File: rtl/sha256_stream_padder.sv
// Byte-stream to SHA-256 block padder: packs bytes into 512-bit blocks, adds 0x80, zero fill and bit length.
// Latency: out_valid 1 cycle after the 64th byte of a full block, 2 cycles after in_last or timeout (PAD + 1).
// Backpressure: in_ready low while padding/sending; out_word and flags held while out_ready is low.
module sha256_stream_padder #(
  parameter int LEN_WIDTH     = 32,
  parameter int TIMEOUT_LIMIT = 10000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [31:0] out_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_first_blk,
  output logic        out_last_blk,
  output logic        out_last_word,
  output logic        busy
);

  localparam int TW = (TIMEOUT_LIMIT > 0) ? $clog2(TIMEOUT_LIMIT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_PAD, S_SEND} state_t;

  state_t               state, state_nxt;
  logic [7:0]           blk_buf [64];
  logic [6:0]           p;
  logic [LEN_WIDTH-1:0] total;
  logic                 msg_end, marker_done, final_q, first_q;
  logic [3:0]           w;
  logic [TW-1:0]        tmo_cnt;
  logic                 in_acc, out_acc, tmo_hit;
  logic [6:0]           zstart, zend;
  logic [63:0]          len_bits;

  assign in_acc   = in_valid && in_ready;
  assign out_acc  = out_valid && out_ready;
  assign tmo_hit  = (TIMEOUT_LIMIT != 0) && (int'(tmo_cnt) >= TIMEOUT_LIMIT);
  // Zero fill starts after the marker, or at p when the marker already went into an earlier block.
  assign zstart   = marker_done ? p : p + 7'd1;
  assign zend     = (p <= 7'd55) ? 7'd55 : 7'd63;
  assign len_bits = 64'(total) << 3;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and handshake/output generation.
  always_comb begin
    state_nxt     = state;
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    out_word      = 32'h0;
    out_first_blk = 1'b0;
    out_last_blk  = 1'b0;
    out_last_word = 1'b0;
    busy          = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = in_last ? S_PAD : S_FILL;
      end
      S_FILL: begin
        if (tmo_hit) begin
          state_nxt = S_PAD;
        end else begin
          in_ready = (p < 7'd64);
          if (in_valid && in_ready) begin
            if (p == 7'd63)   state_nxt = S_SEND;
            else if (in_last) state_nxt = S_PAD;
          end
        end
      end
      S_PAD: state_nxt = S_SEND;
      S_SEND: begin
        out_valid     = 1'b1;
        out_word      = {blk_buf[{w, 2'b00}], blk_buf[{w, 2'b01}],
                         blk_buf[{w, 2'b10}], blk_buf[{w, 2'b11}]};
        out_first_blk = first_q;
        out_last_blk  = final_q;
        out_last_word = (w == 4'd15);
        if (out_ready && w == 4'd15)
          state_nxt = final_q ? S_IDLE : (msg_end ? S_PAD : S_FILL);
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Block buffer, byte counters, message flags and word index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) blk_buf[i] <= 8'h00;
      p           <= 7'd0;
      total       <= '0;
      msg_end     <= 1'b0;
      marker_done <= 1'b0;
      final_q     <= 1'b0;
      first_q     <= 1'b0;
      w           <= 4'd0;
    end else begin
      case (state)
        S_IDLE: if (in_acc) begin
          blk_buf[0]  <= in_byte;
          p           <= 7'd1;
          total       <= LEN_WIDTH'(1);
          first_q     <= 1'b1;
          marker_done <= 1'b0;
          msg_end     <= in_last;
          final_q     <= 1'b0;
          w           <= 4'd0;
        end
        S_FILL: begin
          if (in_acc) begin
            blk_buf[p[5:0]] <= in_byte;
            p               <= p + 7'd1;
            total           <= total + 1'b1;
            if (in_last) msg_end <= 1'b1;
          end else if (tmo_hit) begin
            msg_end <= 1'b1;
          end
        end
        S_PAD: begin
          for (int i = 0; i < 64; i++)
            if (7'(i) >= zstart && 7'(i) <= zend) blk_buf[i] <= 8'h00;
          if (!marker_done && p < 7'd64) blk_buf[p[5:0]] <= 8'h80;
          marker_done <= 1'b1;
          if (p <= 7'd55)
            for (int i = 56; i < 64; i++) blk_buf[i] <= len_bits[8*(63-i) +: 8];
          final_q <= (p <= 7'd55);
        end
        S_SEND: if (out_acc) begin
          w <= w + 4'd1;
          if (w == 4'd15 && !final_q) begin
            p       <= 7'd0;
            first_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Idle-cycle counter inside a message; saturates at the limit, cleared outside FILL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                        tmo_cnt <= '0;
    else if (state != S_FILL || in_acc)                tmo_cnt <= '0;
    else if (int'(tmo_cnt) < TIMEOUT_LIMIT)            tmo_cnt <= tmo_cnt + 1'b1;
  end

endmodule

// File: tb/tb_sha256_stream_padder.sv
// Bench for sha256_stream_padder: fixed vector table, latency/reset sequences and random messages
// checked against a padding model built from the message bytes with plain queue arithmetic.
module tb_sha256_stream_padder;

  localparam int TLIM = 40;

  typedef logic [7:0] bq_t[$];

  typedef struct {
    int          len;
    logic [7:0]  base;
    bit          zero;
    bit          use_last;
    int          lat;
    int          blocks;
    logic [31:0] w0, w1, w15;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_byte = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [31:0] out_word;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_first_blk, out_last_blk, out_last_word, busy;

  int n_cmp = 0;
  int n_err = 0;
  bit rnd_rdy = 1'b0;

  logic [31:0] got_w[$];
  logic        got_f[$], got_l[$], got_lw[$];
  logic [31:0] exp_w[$];
  logic        exp_f[$], exp_l[$], exp_lw[$];

  sha256_stream_padder #(.LEN_WIDTH(32), .TIMEOUT_LIMIT(TLIM)) dut (
    .clk(clk), .rst_n(rst_n), .in_byte(in_byte), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_word(out_word), .out_valid(out_valid), .out_ready(out_ready),
    .out_first_blk(out_first_blk), .out_last_blk(out_last_blk), .out_last_word(out_last_word),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Ready driver: random stalls when enabled, else tied high.
  initial forever begin
    @(posedge clk); #1;
    out_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // Output monitor: collects accepted words and checks stability across stalls.
  initial begin : mon
    logic        stalled;
    logic [31:0] hw;
    logic [2:0]  hf;
    stalled = 1'b0;
    hw = '0;
    hf = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          chk("stall_hold", {out_valid, out_word, out_first_blk, out_last_blk, out_last_word},
              {1'b1, hw, hf});
        end
        if (out_valid && out_ready) begin
          got_w.push_back(out_word);
          got_f.push_back(out_first_blk);
          got_l.push_back(out_last_blk);
          got_lw.push_back(out_last_word);
        end
        stalled = out_valid && !out_ready;
        hw = out_word;
        hf = {out_first_blk, out_last_blk, out_last_word};
      end
    end
  end

  // Reference padding: message, 0x80, zeros to 56 mod 64, 64-bit big-endian bit count.
  task automatic build_exp(input bq_t m);
    bq_t pb;
    logic [63:0] bits;
    int nblk;
    exp_w.delete(); exp_f.delete(); exp_l.delete(); exp_lw.delete();
    pb = m;
    pb.push_back(8'h80);
    while (pb.size() % 64 != 56) pb.push_back(8'h00);
    bits = 64'(m.size()) * 64'd8;
    for (int i = 7; i >= 0; i--) pb.push_back(bits[8*i +: 8]);
    nblk = pb.size() / 64;
    for (int b = 0; b < nblk; b++)
      for (int k = 0; k < 16; k++) begin
        exp_w.push_back({pb[b*64+4*k], pb[b*64+4*k+1], pb[b*64+4*k+2], pb[b*64+4*k+3]});
        exp_f.push_back(b == 0);
        exp_l.push_back(b == nblk - 1);
        exp_lw.push_back(k == 15);
      end
  endtask

  // Drives one message byte by byte; caller is aligned just after a rising edge.
  task automatic send_msg(input bq_t m, input bit use_last, input int gap_max);
    bit acc;
    int n;
    for (int i = 0; i < m.size(); i++) begin
      repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
      in_valid = 1'b1;
      in_byte  = m[i];
      in_last  = use_last && (i == m.size() - 1);
      n = 0;
      do begin
        @(negedge clk); acc = in_ready;
        @(posedge clk); #1; n++;
      end while (!acc && n < 1000);
      if (!acc) chk("in_ready_wait", 32'(n), 32'(0));
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 3000) begin @(posedge clk); #1; n++; end
    if (n >= 3000) chk("idle_wait", 32'(busy), 32'(0));
    @(posedge clk); #1;
  endtask

  // Sends a message, optionally checks output latency, then compares every word against the model.
  task automatic run_msg(input bq_t m, input bit use_last, input int gap_max, input int lat);
    int n;
    got_w.delete(); got_f.delete(); got_l.delete(); got_lw.delete();
    build_exp(m);
    send_msg(m, use_last, gap_max);
    if (lat == 2) begin
      @(negedge clk); chk("lat2_pad_cycle", 32'(out_valid), 32'(0));
      @(negedge clk); chk("lat2_valid", 32'(out_valid), 32'(1));
      chk("lat2_word0", out_word, exp_w[0]);
    end else if (lat == 1) begin
      @(negedge clk); chk("lat1_valid", 32'(out_valid), 32'(1));
    end
    n = 0;
    while (got_w.size() < exp_w.size() && n < 4000) begin @(negedge clk); n++; end
    wait_idle();
    chk("nwords", 32'(got_w.size()), 32'(exp_w.size()));
    for (int k = 0; k < exp_w.size() && k < got_w.size(); k++) begin
      chk($sformatf("word[%0d]", k), got_w[k], exp_w[k]);
      chk($sformatf("flags[%0d]", k), {29'd0, got_f[k], got_l[k], got_lw[k]},
          {29'd0, exp_f[k], exp_l[k], exp_lw[k]});
    end
  endtask

  function automatic vec_t mk(int len, logic [7:0] base, bit zero, bit use_last, int lat,
                              int blocks, logic [31:0] w0, logic [31:0] w1, logic [31:0] w15);
    vec_t v;
    v.len = len; v.base = base; v.zero = zero; v.use_last = use_last; v.lat = lat;
    v.blocks = blocks; v.w0 = w0; v.w1 = w1; v.w15 = w15;
    return v;
  endfunction

  initial begin
    vec_t vecs[8];
    bq_t  m;
    int   bi, n;

    vecs[0] = mk(3,   8'h61, 1'b0, 1'b1, 2, 1, 32'h61626380, 32'h0,        32'h00000018);
    vecs[1] = mk(56,  8'h00, 1'b1, 1'b1, 0, 2, 32'h0,        32'h0,        32'h000001C0);
    vecs[2] = mk(64,  8'h00, 1'b0, 1'b1, 1, 2, 32'h80000000, 32'h0,        32'h00000200);
    vecs[3] = mk(130, 8'h00, 1'b0, 1'b1, 0, 3, 32'h80818000, 32'h0,        32'h00000410);
    vecs[4] = mk(5,   8'h10, 1'b0, 1'b0, 0, 1, 32'h10111213, 32'h14800000, 32'h00000028);
    vecs[5] = mk(55,  8'h00, 1'b0, 1'b1, 0, 1, 32'h00010203, 32'h04050607, 32'h000001B8);
    vecs[6] = mk(1,   8'hAB, 1'b0, 1'b1, 0, 1, 32'hAB800000, 32'h0,        32'h00000008);
    vecs[7] = mk(119, 8'h00, 1'b0, 1'b1, 0, 2, 32'h40414243, 32'h44454647, 32'h000003B8);

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_outs", {27'd0, out_valid, out_first_blk, out_last_blk, out_last_word, busy}, 32'd0);
    chk("rst_word", out_word, 32'h0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    // Table vectors.
    for (int v = 0; v < 8; v++) begin
      m.delete();
      for (int i = 0; i < vecs[v].len; i++) m.push_back(vecs[v].zero ? 8'h00 : vecs[v].base + 8'(i));
      rnd_rdy = (vecs[v].lat == 0);
      run_msg(m, vecs[v].use_last, (vecs[v].lat == 0) ? 2 : 0, vecs[v].lat);
      chk($sformatf("v%0d_blocks", v), 32'(got_w.size() / 16), 32'(vecs[v].blocks));
      if (got_w.size() >= vecs[v].blocks * 16) begin
        bi = (vecs[v].blocks - 1) * 16;
        chk($sformatf("v%0d_last_w0", v), got_w[bi], vecs[v].w0);
        chk($sformatf("v%0d_last_w1", v), got_w[bi+1], vecs[v].w1);
        chk($sformatf("v%0d_last_w15", v), got_w[bi+15], vecs[v].w15);
        chk($sformatf("v%0d_last_blk", v), {30'd0, got_f[bi], got_l[bi]},
            {30'd0, vecs[v].blocks == 1, 1'b1});
      end
    end

    // Reset in the middle of SEND with random stalls, then a clean message.
    rnd_rdy = 1'b1;
    m.delete();
    for (int i = 0; i < 64; i++) m.push_back(8'($urandom));
    got_w.delete(); got_f.delete(); got_l.delete(); got_lw.delete();
    send_msg(m, 1'b1, 0);
    n = 0;
    while (got_w.size() < 5 && n < 1000) begin @(negedge clk); n++; end
    chk("midsend_progress", 32'(got_w.size() >= 5), 32'(1));
    @(posedge clk); #1; rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_outs", {27'd0, out_valid, out_first_blk, out_last_blk, out_last_word, busy}, 32'd0);
    chk("midrst_word", out_word, 32'h0);
    chk("midrst_in_ready", 32'(in_ready), 32'(1));
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    @(posedge clk); #1;
    m.delete();
    m.push_back(8'h61); m.push_back(8'h62); m.push_back(8'h63);
    run_msg(m, 1'b1, 1, 0);

    // Random messages, random gaps and stalls, some ended by timeout.
    for (int r = 0; r < 12; r++) begin
      m.delete();
      n = $urandom_range(1, 200);
      for (int i = 0; i < n; i++) m.push_back(8'($urandom));
      rnd_rdy = 1'b1;
      run_msg(m, ($urandom_range(0, 3) != 0), 3, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sha256_stream_padder.md
Name: sha256_stream_padder

Overview:
- Successor to the single-block UART message packer. Accepts a byte stream of any length, up to 2^LEN_WIDTH−1 bytes, using a valid/ready/last handshake.
- Applies SHA-256 padding: 0x80 marker, zero fill, then the 64-bit big-endian bit length.
- Emits one or more 512-bit blocks as 16 big-endian 32-bit words to the SHA-256 core, with full backpressure.
- Sits between the UART receiver and the hash core. Replaces the fixed 64-byte packer, adds multi-block support and a ready handshake on the core side.

Parameters:
- LEN_WIDTH, 32, width of the message byte counter; the message length wraps modulo 2^LEN_WIDTH.
- TIMEOUT_LIMIT, 10000, idle cycles inside a message before the message is treated as ended; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- in_byte  in  8  message byte
- in_valid  in  1  in_byte valid
- in_last  in  1  in_byte is the final byte of the message
- in_ready  out  1  padder can accept a byte
- out_word  out  32  block word, big-endian (byte 4k in bits 31:24)
- out_valid  out  1  out_word valid
- out_ready  in  1  core accepts out_word
- out_first_blk  out  1  current block is the first block of the message (held for all 16 words)
- out_last_blk  out  1  current block is the final block of the message (held for all 16 words)
- out_last_word  out  1  current word is word 15
- busy  out  1  not in IDLE

Behaviour:
- Reset: state IDLE. in_ready=1; out_valid, out_first_blk, out_last_blk, out_last_word, busy and out_word all 0. Buffer, byte count, block pointer, word index and timeout counter cleared. Reset mid-message discards everything; there is no partial output after reset.
- Transfers: a byte is accepted when in_valid&&in_ready; a word is accepted when out_valid&&out_ready.
- Internal state:
  - 64-byte buffer and 7-bit block pointer p (0..64).
  - LEN_WIDTH total byte count.
  - Flags: msg_end, marker_done, final, first.
- IDLE:
  - in_ready=1.
  - Accepted byte is written to buf[0]; p=1, total=1, first=1, marker_done=0.
  - If in_last, set msg_end and go to PAD; otherwise go to FILL.
- FILL:
  - in_ready=1 while p<64.
  - Each accepted byte goes to buf[p]; p and total increment.
  - If the byte that makes p=64 is not last: go to SEND with final=0.
  - If it is last (p=64): set msg_end and go to SEND with final=0, marker_done=0.
  - If in_last with p<64: set msg_end and go to PAD.
  - Timeout counter: cleared on each accepted byte, incremented otherwise, saturates. Reaching TIMEOUT_LIMIT (when nonzero) sets msg_end and goes to PAD. in_ready is 0 in that cycle.
- PAD (exactly 1 cycle, in_ready=0):
  - If !marker_done, write 0x80 at buf[p] (when p<64) and set marker_done.
  - Zero every byte after the marker, or from p if the marker was already placed, up to byte 55 if p≤55, else up to byte 63.
  - If p≤55: write total×8 into bytes 56..63 as a 64-bit big-endian value, zero-extended; set final=1.
  - If p>55: final=0.
  - Go to SEND.
- SEND:
  - out_valid=1; out_word = buf[4w..4w+3], where w is the word index.
  - out_word and all flags are held stable while !out_ready.
  - w advances on each accepted word. On acceptance of word 15:
    - final: go to IDLE.
    - msg_end && !final: p=0, first=0, go to PAD. This covers the extra length block and the length-multiple-of-64 case.
    - Otherwise: p=0, first=0, go to FILL.
- Latency:
  - out_valid rises 1 cycle after the 64th byte of a full block.
  - out_valid rises 2 cycles after acceptance of in_last or the timeout cycle (PAD + 1).
  - A 16-word block takes 16 cycles with out_ready tied high.
- Simultaneous events: in_last together with the 64th byte follows the p=64 rule above. in_valid is ignored whenever in_ready=0. A timeout is not evaluated in IDLE, so an empty message is never produced.

Test Plan:
- "abc" (0x61,0x62,0x63, last on 0x63), out_ready=1 -> one block: w0=0x61626380, w1..w14=0, w15=0x00000018; first_blk=last_blk=1; out_valid rises 2 cycles after the last byte.
- 56 bytes of 0x00, last on byte 56 -> block 1 has w14=0x80000000, w15=0, last_blk=0. Block 2 has w0..w13=0, w15=0x000001C0, first_blk=0, last_blk=1.
- 64 bytes, last on byte 64 -> block 1 holds raw data. Block 2: w0=0x80000000, w15=0x00000200, last_blk=1.
- 130-byte message -> three blocks, first_blk only on block 1. Block 3 w0 holds bytes 128..129 followed by 0x80 and 0x00; w15=0x00000410.
- 5 bytes, no in_last, then idle for TIMEOUT_LIMIT cycles -> padded single block with w1 = byte4 followed by 0x800000, w15=0x00000028.
- out_ready toggled randomly, plus rst_n asserted mid-SEND -> words held stable while stalled, no word lost or duplicated. After reset, all outputs are 0 and the next message starts cleanly.
